// File: rtl/alu_seq_if.sv
// Handshake bundle for alu_seq: operand/opcode request side and result/flags response side.
// The master drives requests and takes results; the slave is the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             zero_flag;
    logic             carry_flag;
    logic             overflow_flag;
    logic             negative_flag;

    modport master (
        output in_valid, opcode, a, b, out_ready,
        input  in_ready, out_valid, res, zero_flag, carry_flag, overflow_flag, negative_flag
    );

    modport slave (
        input  in_valid, opcode, a, b, out_ready,
        output in_ready, out_valid, res, zero_flag, carry_flag, overflow_flag, negative_flag
    );
endinterface

// File: rtl/alu_seq.sv
// Registered, handshaked ALU with single-cycle logic/arith/shift ops and an iterative
// shift-add multiplier. Result and flags are held in DONE until the consumer takes them.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam bit SH_CAN_OVER = ((2 ** SHW) != WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             z_q, z_d, c_q, c_d, v_q, v_d, n_q, n_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mpl_q, mpl_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             accept_s;
    logic             mul_last_s;
    logic [SHW-1:0]   sh_s;
    logic             sh_big_s;
    logic [WIDTH:0]   add_s, sub_s, shl_s, shr_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_c_s, alu_v_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH-1:0] acc_nx_s, mpl_nx_s;
    logic             load_s;
    logic [WIDTH-1:0] ld_res_s;
    logic             ld_c_s, ld_v_s;

    assign accept_s   = bus.in_valid && (state_q == S_IDLE);
    assign mul_last_s = (cnt_q == CW'(WIDTH - 1));
    assign sh_s       = bus.b[SHW-1:0];
    assign sh_big_s   = SH_CAN_OVER && (32'(sh_s) >= 32'(WIDTH));

    // Single-cycle operation results with carry and signed-overflow.
    always_comb begin
        add_s     = {1'b0, bus.a} + {1'b0, bus.b};
        sub_s     = {1'b0, bus.a} - {1'b0, bus.b};
        shl_s     = {1'b0, bus.a} << sh_s;
        shr_s     = {bus.a, 1'b0} >> sh_s;
        alu_res_s = '0;
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                alu_res_s = add_s[WIDTH-1:0];
                alu_c_s   = add_s[WIDTH];
                alu_v_s   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_s[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_s = sub_s[WIDTH-1:0];
                alu_c_s   = sub_s[WIDTH];
                alu_v_s   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_s[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND: alu_res_s = bus.a & bus.b;
            OP_OR:  alu_res_s = bus.a | bus.b;
            OP_XOR: alu_res_s = bus.a ^ bus.b;
            OP_NOT: alu_res_s = ~bus.a;
            OP_SHL: begin
                if (sh_big_s) begin
                    alu_res_s = '0;
                    alu_c_s   = 1'b0;
                end else begin
                    alu_res_s = shl_s[WIDTH-1:0];
                    alu_c_s   = shl_s[WIDTH];
                end
            end
            OP_SHR: begin
                if (sh_big_s) begin
                    alu_res_s = '0;
                    alu_c_s   = 1'b0;
                end else begin
                    alu_res_s = shr_s[WIDTH:1];
                    alu_c_s   = shr_s[0];
                end
            end
            default: begin
                alu_res_s = '0;
                alu_c_s   = 1'b0;
                alu_v_s   = 1'b0;
            end
        endcase
    end

    // One shift-add step: acc:mpl holds the partial product, mpl's LSB selects the add.
    always_comb begin
        mul_sum_s = {1'b0, acc_q} + (mpl_q[0] ? {1'b0, mcand_q} : {(WIDTH + 1){1'b0}});
        acc_nx_s  = mul_sum_s[WIDTH:1];
        mpl_nx_s  = {mul_sum_s[0], mpl_q[WIDTH-1:1]};
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = (bus.opcode == OP_MUL) ? S_MUL : S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (mul_last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: multiplier iteration and result/flag capture.
    always_comb begin
        mcand_d  = mcand_q;
        mpl_d    = mpl_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        load_s   = 1'b0;
        ld_res_s = alu_res_s;
        ld_c_s   = alu_c_s;
        ld_v_s   = alu_v_s;
        case (state_q)
            S_IDLE: begin
                if (accept_s && (bus.opcode == OP_MUL)) begin
                    mcand_d = bus.a;
                    mpl_d   = bus.b;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (accept_s) begin
                    load_s  = 1'b1;
                end else begin
                    load_s  = 1'b0;
                end
            end
            S_MUL: begin
                acc_d = acc_nx_s;
                mpl_d = mpl_nx_s;
                cnt_d = cnt_q + CW'(1);
                if (mul_last_s) begin
                    load_s   = 1'b1;
                    ld_res_s = mpl_nx_s;
                    ld_c_s   = |acc_nx_s;
                    ld_v_s   = 1'b0;
                end else begin
                    load_s   = 1'b0;
                end
            end
            default: load_s = 1'b0;
        endcase

        if (load_s) begin
            res_d = ld_res_s;
            z_d   = (ld_res_s == '0);
            c_d   = ld_c_s;
            v_d   = ld_v_s;
            n_d   = ld_res_s[WIDTH-1];
        end else begin
            res_d = res_q;
            z_d   = z_q;
            c_d   = c_q;
            v_d   = v_q;
            n_d   = n_q;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset discards any in-flight multiply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            n_q     <= 1'b0;
            mcand_q <= '0;
            mpl_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            res_q   <= res_d;
            z_q     <= z_d;
            c_q     <= c_d;
            v_q     <= v_d;
            n_q     <= n_d;
            mcand_q <= mcand_d;
            mpl_q   <= mpl_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decoded from registered state and captured result.
    always_comb begin
        bus.in_ready      = (state_q == S_IDLE);
        bus.out_valid     = (state_q == S_DONE);
        bus.res           = res_q;
        bus.zero_flag     = z_q;
        bus.carry_flag    = c_q;
        bus.overflow_flag = v_q;
        bus.negative_flag = n_q;
    end
endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq (WIDTH=8) against an arithmetic reference model.
module tb_alu_seq;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns {res[7:0], Z, C, V, N} from plain integer arithmetic on the opcode rules.
    function automatic logic [11:0] ref_op(input int op, input int av, input int bv);
        int r, c, v, sa, sb, sr, sh;
        logic [31:0] rv;
        sh = bv % 8;
        sa = (av > 127) ? av - 256 : av;
        sb = (bv > 127) ? bv - 256 : bv;
        c = 0;
        v = 0;
        case (op)
            0: begin r = av + bv; c = (r > 255) ? 1 : 0; sr = sa + sb; v = (sr > 127 || sr < -128) ? 1 : 0; end
            1: begin r = av - bv; c = (av < bv) ? 1 : 0; sr = sa - sb; v = (sr > 127 || sr < -128) ? 1 : 0; end
            2: r = av & bv;
            3: r = av | bv;
            4: r = av ^ bv;
            5: r = 255 - av;
            6: begin r = av * (1 << sh); c = (sh == 0) ? 0 : (av >> (8 - sh)) & 1; end
            7: begin r = av / (1 << sh); c = (sh == 0) ? 0 : (av >> (sh - 1)) & 1; end
            8: begin r = av * bv; c = (r > 255) ? 1 : 0; end
            default: r = 0;
        endcase
        rv = 32'(r % 256);
        return {rv[7:0], (rv[7:0] == 8'd0), c[0], v[0], rv[7]};
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv, input int stall);
        logic [11:0] e;
        int lat;
        int exp_lat;
        e = ref_op(int'(op), int'(av), int'(bv));
        exp_lat = (op == 4'd8) ? W + 1 : 1;
        @(negedge clk);
        check_eq("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid  = 1'b1;
        bus.opcode    = op;
        bus.a         = av;
        bus.b         = bv;
        bus.out_ready = 1'b0;
        @(negedge clk);
        // Garbage operands with in_valid high must be ignored while busy.
        bus.opcode = 4'($urandom);
        bus.a      = 8'($urandom);
        bus.b      = 8'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            if (lat == 2) check_eq("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
            @(negedge clk);
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("res", {24'd0, bus.res}, {24'd0, e[11:4]});
        check_eq("flags_zcvn", {28'd0, bus.zero_flag, bus.carry_flag, bus.overflow_flag, bus.negative_flag},
                 {28'd0, e[3:0]});
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_eq("hold", {22'd0, bus.out_valid, bus.in_ready, bus.res}, {22'd0, 1'b1, 1'b0, e[11:4]});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_eq("release", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.opcode    = 4'd0;
        bus.a         = 8'd0;
        bus.b         = 8'd0;
        bus.out_ready = 1'b0;
        #12;
        check_eq("reset_state", {19'd0, bus.in_ready, bus.out_valid, bus.res, bus.zero_flag, bus.carry_flag,
                 bus.overflow_flag, bus.negative_flag}, {19'd0, 1'b1, 1'b0, 8'h00, 4'h0});
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd0, 8'h7F, 8'h01, 0);
        run_op(4'd0, 8'hFF, 8'h01, 1);
        run_op(4'd1, 8'h00, 8'h01, 0);
        run_op(4'd8, 8'h10, 8'h10, 0);
        run_op(4'd8, 8'h0D, 8'h0B, 2);
        run_op(4'd6, 8'h81, 8'h01, 0);
        run_op(4'd7, 8'h81, 8'h00, 0);
        run_op(4'd15, 8'hAB, 8'hCD, 0);
        run_op(4'd4, 8'hF0, 8'hFF, 5);

        // Asynchronous reset between edges in the middle of a multiply.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = 4'd8;
        bus.a        = 8'h0D;
        bus.b        = 8'h0B;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_reset", {19'd0, bus.in_ready, bus.out_valid, bus.res, bus.zero_flag, bus.carry_flag,
                 bus.overflow_flag, bus.negative_flag}, {19'd0, 1'b1, 1'b0, 8'h00, 4'h0});
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'd8, 8'hFF, 8'hFF, 0);

        for (int k = 0; k < 60; k++) begin
            run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
